midi_byte_parser: RTL and testbench

- Upstream stage of the MIDI input mux and status decoder. Turns the raw received-byte strobe stream from the MIDI UART receiver into framed MIDI data.
- Frames it as byteready / cur_status / midibyte_nr / midi_in_data.
- Handles running status, system exclusive, system common and realtime interleaving.
- Downstream stages see one registered pulse per accepted byte, with a message-relative byte index.

---
 rtl/midi_byte_parser_if.sv | 41 ++++
 rtl/midi_byte_parser.sv | 167 ++++++++++++++++
 tb/tb_midi_byte_parser.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_byte_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : midi_byte_parser_if
// Purpose  : Byte-strobe input and framed-byte output bundle of the MIDI
//            byte parser. MIDI_REALTIME_OUT_EN adds the realtime side channel.
// Revision : 1.0 - initial release
// ============================================================================
interface midi_byte_parser_if;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       byteready;
   logic [7:0] cur_status;
   logic [7:0] midibyte_nr;
   logic [7:0] midi_in_data;
   logic [7:0] stray_cnt;
`ifdef MIDI_REALTIME_OUT_EN
   logic       rt_valid;
   logic [7:0] rt_byte;

   modport master (
      output rx_byte, rx_valid,
      input  byteready, cur_status, midibyte_nr, midi_in_data, stray_cnt,
      input  rt_valid, rt_byte
   );
   modport slave (
      input  rx_byte, rx_valid,
      output byteready, cur_status, midibyte_nr, midi_in_data, stray_cnt,
      output rt_valid, rt_byte
   );
`else
   modport master (
      output rx_byte, rx_valid,
      input  byteready, cur_status, midibyte_nr, midi_in_data, stray_cnt
   );
   modport slave (
      input  rx_byte, rx_valid,
      output byteready, cur_status, midibyte_nr, midi_in_data, stray_cnt
   );
`endif
endinterface
`default_nettype wire

// File: rtl/midi_byte_parser.sv
`default_nettype none
// ============================================================================
// Module   : midi_byte_parser
// Purpose  : Frames received MIDI bytes (running status, sysex, system common,
//            realtime). Optional macro MIDI_REALTIME_OUT_EN adds rt_valid/rt_byte.
// Revision : 1.0 - initial release
// ============================================================================
module midi_byte_parser #(
   parameter int NR_SAT     = 255,
   parameter int RS_TIMEOUT = 0
) (
   input  wire logic         CLOCK_50,
   input  wire logic         reset_reg,
   midi_byte_parser_if.slave bus
);
   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_CHAN   = 2'd1;
   localparam logic [1:0] c_ST_SYSEX  = 2'd2;
   localparam logic [1:0] c_ST_SYSCOM = 2'd3;
   localparam logic [7:0] c_NR_SAT    = 8'(NR_SAT);

   logic [1:0] r_state;
   logic [1:0] r_idx;
   logic [1:0] r_len;
   logic       r_byteready;
   logic       r_clr_pend;
   logic [7:0] r_cur_status;
   logic [7:0] r_nr;
   logic [7:0] r_data;
   logic [7:0] r_stray;

   logic       w_is_rt;
   logic       w_byte_in;
   logic       w_tmo_fire;
   logic [1:0] w_idx_inc;
   logic [1:0] w_len_new;

   assign w_is_rt   = (bus.rx_byte[7:3] == 5'b11111);
   assign w_byte_in = bus.rx_valid && !w_is_rt;
   assign w_idx_inc = r_idx + 2'd1;

   always_comb begin
      w_len_new = 2'd2;
      if (bus.rx_byte[7:4] == 4'hC || bus.rx_byte[7:4] == 4'hD ||
          bus.rx_byte == 8'hF1 || bus.rx_byte == 8'hF3)
         w_len_new = 2'd1;
   end

   generate
      if (RS_TIMEOUT > 0) begin : g_timeout
         localparam int                 c_TMO_W   = $clog2(RS_TIMEOUT + 1);
         localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(RS_TIMEOUT);
         logic [c_TMO_W-1:0] r_tmo_cnt;

         always_ff @(posedge CLOCK_50 or posedge reset_reg) begin
            if (reset_reg)
               r_tmo_cnt <= '0;
            else if (w_byte_in)
               r_tmo_cnt <= '0;
            else if (r_tmo_cnt != c_TMO_MAX)
               r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end

         assign w_tmo_fire = !w_byte_in && (r_tmo_cnt == c_TMO_MAX - 1'b1);
      end else begin : g_no_timeout
         assign w_tmo_fire = 1'b0;
      end
   endgenerate

   always_ff @(posedge CLOCK_50 or posedge reset_reg) begin
      if (reset_reg) begin
         r_state      <= c_ST_IDLE;
         r_idx        <= 2'd0;
         r_len        <= 2'd0;
         r_byteready  <= 1'b0;
         r_clr_pend   <= 1'b0;
         r_cur_status <= 8'h00;
         r_nr         <= 8'h00;
         r_data       <= 8'h00;
         r_stray      <= 8'h00;
      end else begin
         r_byteready <= 1'b0;
         r_clr_pend  <= 1'b0;
         // A terminating byte shows its own status for one pulse, then none.
         if (r_clr_pend)
            r_cur_status <= 8'h00;

         if (w_byte_in) begin
            if (!bus.rx_byte[7]) begin
               case (r_state)
                  c_ST_CHAN, c_ST_SYSCOM: begin
                     r_byteready <= 1'b1;
                     r_data      <= bus.rx_byte;
                     r_nr        <= {6'd0, w_idx_inc};
                     if (w_idx_inc == r_len) begin
                        r_idx <= 2'd0;
                        if (r_state == c_ST_SYSCOM) begin
                           r_state    <= c_ST_IDLE;
                           r_clr_pend <= 1'b1;
                        end
                     end else begin
                        r_idx <= w_idx_inc;
                     end
                  end
                  c_ST_SYSEX: begin
                     r_byteready <= 1'b1;
                     r_data      <= bus.rx_byte;
                     r_nr        <= (r_nr >= c_NR_SAT) ? c_NR_SAT : r_nr + 8'd1;
                  end
                  default: begin
                     if (r_stray != 8'hFF)
                        r_stray <= r_stray + 8'd1;
                  end
               endcase
            end else begin
               r_byteready  <= 1'b1;
               r_data       <= bus.rx_byte;
               r_nr         <= 8'h00;
               r_cur_status <= bus.rx_byte;
               r_idx        <= 2'd0;
               r_len        <= w_len_new;
               if (bus.rx_byte < 8'hF0)
                  r_state <= c_ST_CHAN;
               else if (bus.rx_byte == 8'hF0)
                  r_state <= c_ST_SYSEX;
               else if (bus.rx_byte <= 8'hF3)
                  r_state <= c_ST_SYSCOM;
               else begin
                  r_state    <= c_ST_IDLE;
                  r_clr_pend <= 1'b1;
               end
            end
         end else if (w_tmo_fire && (r_state == c_ST_CHAN || r_state == c_ST_SYSCOM)) begin
            r_state      <= c_ST_IDLE;
            r_idx        <= 2'd0;
            r_cur_status <= 8'h00;
         end
      end
   end

   assign bus.byteready    = r_byteready;
   assign bus.cur_status   = r_cur_status;
   assign bus.midibyte_nr  = r_nr;
   assign bus.midi_in_data = r_data;
   assign bus.stray_cnt    = r_stray;

`ifdef MIDI_REALTIME_OUT_EN
   logic       r_rt_valid;
   logic [7:0] r_rt_byte;

   always_ff @(posedge CLOCK_50 or posedge reset_reg) begin
      if (reset_reg) begin
         r_rt_valid <= 1'b0;
         r_rt_byte  <= 8'h00;
      end else begin
         r_rt_valid <= bus.rx_valid && w_is_rt;
         if (bus.rx_valid && w_is_rt)
            r_rt_byte <= bus.rx_byte;
      end
   end

   assign bus.rt_valid = r_rt_valid;
   assign bus.rt_byte  = r_rt_byte;
`endif

endmodule
`default_nettype wire

// File: tb/tb_midi_byte_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_midi_byte_parser
// Purpose  : Vector table, directed corner sequences and random stimulus
//            against a message-level reference model, on two configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_midi_byte_parser;
   localparam int c_SAT0 = 255;
   localparam int c_TMO0 = 0;
   localparam int c_SAT1 = 100;
   localparam int c_TMO1 = 16;

   logic CLOCK_50 = 1'b0;
   logic reset_reg;

   midi_byte_parser_if bus0 ();
   midi_byte_parser_if bus1 ();

   midi_byte_parser #(.NR_SAT(c_SAT0), .RS_TIMEOUT(c_TMO0)) dut0 (
      .CLOCK_50 (CLOCK_50),
      .reset_reg(reset_reg),
      .bus      (bus0.slave)
   );
   midi_byte_parser #(.NR_SAT(c_SAT1), .RS_TIMEOUT(c_TMO1)) dut1 (
      .CLOCK_50 (CLOCK_50),
      .reset_reg(reset_reg),
      .bus      (bus1.slave)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: tracks the running message and how many data bytes it has had.
   int         m_run  [2];
   int         m_cnt  [2];
   int         m_idle [2];
   logic [7:0] m_shown[2];
   logic [7:0] m_nr   [2];
   logic [7:0] m_data [2];
   logic [7:0] m_stray[2];
   logic [7:0] m_rtb  [2];
   logic       m_br   [2];
   logic       m_rtv  [2];

   function automatic int msg_len(input int s);
      if (s == 'hF2) return 2;
      if (s == 'hF1 || s == 'hF3) return 1;
      if ((s >> 4) == 'hC || (s >> 4) == 'hD) return 1;
      return 2;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_run[k] = 0;  m_cnt[k] = 0;  m_idle[k] = 0;
         m_shown[k] = 0; m_nr[k] = 0; m_data[k] = 0; m_stray[k] = 0;
         m_rtb[k] = 0;  m_br[k] = 0;  m_rtv[k] = 0;
      end
   endtask

   task automatic model_step(input int k, input logic v, input logic [7:0] b,
                             input int sat, input int tmo);
      m_br[k]  = 1'b0;
      m_rtv[k] = 1'b0;
      if (m_run[k] == 0) m_shown[k] = 8'h00;
      if (v && b < 8'hF8) begin
         m_idle[k] = 0;
         if (b < 8'h80) begin
            if (m_run[k] == 0) begin
               if (m_stray[k] != 8'hFF) m_stray[k] = m_stray[k] + 8'd1;
            end else begin
               m_br[k] = 1'b1;  m_data[k] = b;  m_shown[k] = 8'(m_run[k]);
               if (m_run[k] == 'hF0) begin
                  m_nr[k] = (int'(m_nr[k]) < sat) ? m_nr[k] + 8'd1 : 8'(sat);
               end else begin
                  m_cnt[k]++;
                  m_nr[k] = 8'(m_cnt[k]);
                  if (m_cnt[k] == msg_len(m_run[k])) begin
                     m_cnt[k] = 0;
                     if (m_run[k] >= 'hF1) m_run[k] = 0;
                  end
               end
            end
         end else begin
            m_br[k] = 1'b1;  m_data[k] = b;  m_nr[k] = 0;  m_shown[k] = b;  m_cnt[k] = 0;
            m_run[k] = (b <= 8'hF3) ? int'(b) : 0;
         end
      end else begin
         if (v) begin m_rtv[k] = 1'b1; m_rtb[k] = b; end
         if (m_idle[k] < 1000000) m_idle[k]++;
         if (tmo > 0 && m_idle[k] == tmo && m_run[k] != 0 && m_run[k] != 'hF0) begin
            m_run[k] = 0;  m_shown[k] = 0;  m_cnt[k] = 0;
         end
      end
   endtask

   task automatic check_model(input int k, input logic br, input logic [7:0] cs,
                              input logic [7:0] nr, input logic [7:0] d, input logic [7:0] sc);
      n_cmp++;
      if (br !== m_br[k] || cs !== m_shown[k] || nr !== m_nr[k] || d !== m_data[k] || sc !== m_stray[k]) begin
         n_err++;
         $display("FAIL model dut%0d t=%0t got br=%b cs=%h nr=%0d d=%h stray=%0d, expected br=%b cs=%h nr=%0d d=%h stray=%0d",
                  k, $time, br, cs, nr, d, sc, m_br[k], m_shown[k], m_nr[k], m_data[k], m_stray[k]);
      end
   endtask

   task automatic check_rt(input int k, input logic rtv, input logic [7:0] rtb);
      n_cmp++;
      if (rtv !== m_rtv[k] || rtb !== m_rtb[k]) begin
         n_err++;
         $display("FAIL model_rt dut%0d t=%0t got rt_valid=%b rt_byte=%h, expected %b %h",
                  k, $time, rtv, rtb, m_rtv[k], m_rtb[k]);
      end
   endtask

   always @(posedge CLOCK_50) begin
      if (reset_reg) begin
         model_reset();
      end else begin
         model_step(0, bus0.rx_valid, bus0.rx_byte, c_SAT0, c_TMO0);
         model_step(1, bus1.rx_valid, bus1.rx_byte, c_SAT1, c_TMO1);
      end
      #1;
      check_model(0, bus0.byteready, bus0.cur_status, bus0.midibyte_nr, bus0.midi_in_data, bus0.stray_cnt);
      check_model(1, bus1.byteready, bus1.cur_status, bus1.midibyte_nr, bus1.midi_in_data, bus1.stray_cnt);
`ifdef MIDI_REALTIME_OUT_EN
      check_rt(0, bus0.rt_valid, bus0.rt_byte);
      check_rt(1, bus1.rt_valid, bus1.rt_byte);
`endif
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle on both DUTs, then settle just after the sampling edge.
   task automatic step(input logic v, input logic [7:0] b);
      @(negedge CLOCK_50);
      bus0.rx_valid = v;  bus0.rx_byte = b;
      bus1.rx_valid = v;  bus1.rx_byte = b;
      @(posedge CLOCK_50);
      #2;
   endtask

   task automatic do_reset();
      @(negedge CLOCK_50);
      reset_reg = 1'b1;
      bus0.rx_valid = 1'b0;  bus1.rx_valid = 1'b0;
      @(negedge CLOCK_50);
      reset_reg = 1'b0;
   endtask

   typedef struct {
      logic       rst;
      logic       v;
      logic [7:0] b;
      logic       br;
      logic [7:0] cs;
      logic [7:0] nr;
      logic [7:0] d;
      logic [7:0] sc;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic v, input logic [7:0] b, input logic br,
                               input logic [7:0] cs, input logic [7:0] nr, input logic [7:0] d,
                               input logic [7:0] sc);
      vec_t t;
      t.rst = rst; t.v = v; t.b = b; t.br = br; t.cs = cs; t.nr = nr; t.d = d; t.sc = sc;
      return t;
   endfunction

   function automatic logic [7:0] rand_byte();
      int r;
      r = $urandom_range(0, 99);
      if (r < 50) return 8'($urandom_range(0, 127));
      if (r < 72) return 8'($urandom_range(128, 239));
      if (r < 85) return 8'($urandom_range(240, 247));
      return 8'($urandom_range(248, 255));
   endfunction

   initial begin
      vec_t tbl[$];
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl[$];
      reset_reg = 1'b1;
      bus0.rx_valid = 1'b0;  bus0.rx_byte = 8'h00;
      bus1.rx_valid = 1'b0;  bus1.rx_byte = 8'h00;

      //                 rst  v    byte   br   cs     nr    data   stray
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0, 8'h00, 8'd0));
      tbl.push_back(mk(1'b0, 1'b1, 8'h90, 1'b1, 8'h90, 8'd0, 8'h90, 8'd0));
      tbl.push_back(mk(1'b0, 1'b1, 8'h3C, 1'b1, 8'h90, 8'd1, 8'h3C, 8'd0));
      tbl.push_back(mk(1'b0, 1'b1, 8'h64, 1'b1, 8'h90, 8'd2, 8'h64, 8'd0));
      tbl.push_back(mk(1'b0, 1'b1, 8'h3C, 1'b1, 8'h90, 8'd1, 8'h3C, 8'd0));
      tbl.push_back(mk(1'b0, 1'b1, 8'h00, 1'b1, 8'h90, 8'd2, 8'h00, 8'd0));
      tbl.push_back(mk(1'b0, 1'b1, 8'hC2, 1'b1, 8'hC2, 8'd0, 8'hC2, 8'd0));
      tbl.push_back(mk(1'b0, 1'b1, 8'h05, 1'b1, 8'hC2, 8'd1, 8'h05, 8'd0));
      tbl.push_back(mk(1'b0, 1'b1, 8'h07, 1'b1, 8'hC2, 8'd1, 8'h07, 8'd0));
      tbl.push_back(mk(1'b0, 1'b1, 8'h90, 1'b1, 8'h90, 8'd0, 8'h90, 8'd0));
      tbl.push_back(mk(1'b0, 1'b1, 8'h3C, 1'b1, 8'h90, 8'd1, 8'h3C, 8'd0));
      tbl.push_back(mk(1'b0, 1'b1, 8'hF8, 1'b0, 8'h90, 8'd1, 8'h3C, 8'd0));
      tbl.push_back(mk(1'b0, 1'b1, 8'h64, 1'b1, 8'h90, 8'd2, 8'h64, 8'd0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0, 8'h00, 8'd0));
      tbl.push_back(mk(1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 8'd0, 8'h00, 8'd1));
      tbl.push_back(mk(1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 8'd0, 8'h00, 8'd2));
      tbl.push_back(mk(1'b0, 1'b1, 8'hF2, 1'b1, 8'hF2, 8'd0, 8'hF2, 8'd2));
      tbl.push_back(mk(1'b0, 1'b1, 8'h10, 1'b1, 8'hF2, 8'd1, 8'h10, 8'd2));
      tbl.push_back(mk(1'b0, 1'b1, 8'h20, 1'b1, 8'hF2, 8'd2, 8'h20, 8'd2));
      tbl.push_back(mk(1'b0, 1'b1, 8'h30, 1'b0, 8'h00, 8'd2, 8'h20, 8'd3));
      tbl.push_back(mk(1'b0, 1'b1, 8'hF6, 1'b1, 8'hF6, 8'd0, 8'hF6, 8'd3));
      tbl.push_back(mk(1'b0, 1'b1, 8'hFE, 1'b0, 8'h00, 8'd0, 8'hF6, 8'd3));
      tbl.push_back(mk(1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 8'd0, 8'hF6, 8'd4));

      repeat (2) @(negedge CLOCK_50);
      reset_reg = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) begin
            @(negedge CLOCK_50);
            reset_reg = 1'b1;
            bus0.rx_valid = 1'b0;  bus1.rx_valid = 1'b0;
            #1;
         end else begin
            step(tbl[i].v, tbl[i].b);
         end
         n_cmp++;
         if (bus0.byteready !== tbl[i].br || bus0.cur_status !== tbl[i].cs ||
             bus0.midibyte_nr !== tbl[i].nr || bus0.midi_in_data !== tbl[i].d ||
             bus0.stray_cnt !== tbl[i].sc) begin
            n_err++;
            $display("FAIL vec[%0d] got br=%b cs=%h nr=%0d d=%h stray=%0d, expected br=%b cs=%h nr=%0d d=%h stray=%0d",
                     i, bus0.byteready, bus0.cur_status, bus0.midibyte_nr, bus0.midi_in_data, bus0.stray_cnt,
                     tbl[i].br, tbl[i].cs, tbl[i].nr, tbl[i].d, tbl[i].sc);
         end
         if (tbl[i].rst) begin
            @(negedge CLOCK_50);
            reset_reg = 1'b0;
         end
      end
      step(1'b0, 8'h00);

      // Long sysex: index climbs then saturates, F7 ends it.
      do_reset();
      step(1'b1, 8'hF0);
      chk("sysex_start_nr", bus0.midibyte_nr, 0);
      chk("sysex_start_cs", bus0.cur_status, 8'hF0);
      for (int i = 1; i <= 300; i++) begin
         step(1'b1, 8'(i & 'h7F));
         chk("sysex_nr", bus0.midibyte_nr, (i < 255) ? i : 255);
      end
      step(1'b1, 8'hF7);
      chk("sysex_end_br", bus0.byteready, 1);
      chk("sysex_end_nr", bus0.midibyte_nr, 0);
      chk("sysex_end_cs", bus0.cur_status, 8'hF7);
      step(1'b0, 8'h00);
      chk("sysex_after_cs", bus0.cur_status, 8'h00);
      chk("sysex_after_br", bus0.byteready, 0);

      // Reset mid-message clears outputs at once; the next data byte is stray.
      step(1'b1, 8'h90);
      step(1'b1, 8'h3C);
      @(negedge CLOCK_50);
      reset_reg = 1'b1;
      bus0.rx_valid = 1'b0;  bus1.rx_valid = 1'b0;
      #1;
      chk("async_rst_br", bus0.byteready, 0);
      chk("async_rst_cs", bus0.cur_status, 0);
      chk("async_rst_nr", bus0.midibyte_nr, 0);
      chk("async_rst_data", bus0.midi_in_data, 0);
      @(negedge CLOCK_50);
      reset_reg = 1'b0;
      step(1'b1, 8'h40);
      chk("post_rst_stray", bus0.stray_cnt, 1);
      chk("post_rst_br", bus0.byteready, 0);

      // Running-status timeout on the RS_TIMEOUT=16 instance.
      do_reset();
      step(1'b1, 8'hB0);
      step(1'b1, 8'h07);
      step(1'b1, 8'h7F);
      repeat (15) step(1'b0, 8'h00);
      step(1'b1, 8'h10);
      chk("tmo15_br", bus1.byteready, 1);
      chk("tmo15_cs", bus1.cur_status, 8'hB0);
      chk("tmo15_nr", bus1.midibyte_nr, 1);
      step(1'b1, 8'h20);
      chk("tmo15_nr2", bus1.midibyte_nr, 2);
      repeat (16) step(1'b0, 8'h00);
      chk("tmo16_cs", bus1.cur_status, 8'h00);
      step(1'b1, 8'h10);
      chk("tmo16_br", bus1.byteready, 0);
      chk("tmo16_stray", bus1.stray_cnt, 1);
      chk("notmo_br", bus0.byteready, 1);

`ifdef MIDI_REALTIME_OUT_EN
      do_reset();
      step(1'b1, 8'h90);
      step(1'b1, 8'h3C);
      step(1'b1, 8'hF8);
      chk("rt_valid", bus0.rt_valid, 1);
      chk("rt_byte", bus0.rt_byte, 8'hF8);
      chk("rt_br", bus0.byteready, 0);
      step(1'b1, 8'h64);
      chk("rt_valid_drop", bus0.rt_valid, 0);
      chk("rt_byte_hold", bus0.rt_byte, 8'hF8);
      chk("rt_after_nr", bus0.midibyte_nr, 2);
`endif

      // Random traffic, checked every cycle against the reference model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 999);
         if (r < 3) begin
            do_reset();
         end else if (r < 20) begin
            repeat ($urandom_range(10, 20)) step(1'b0, 8'($urandom));
         end else if (r < 25) begin
            step(1'b1, 8'hF0);
            repeat ($urandom_range(90, 130)) step(1'b1, 8'($urandom_range(0, 127)));
         end else if (r < 300) begin
            step(1'b0, 8'($urandom));
         end else begin
            step(1'b1, rand_byte());
         end
      end
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
